// File: rtl/instruction_fetch_stage_pkg.sv
// Shared IF/ID pipeline definitions, reused by the fetch stage, the ID stage and the hazard unit.
// Holds the IF/ID bundle layout, the reset/bubble constants and word-alignment helpers.
package instruction_fetch_stage_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_LOAD   = 2'b01,
        IFID_BUBBLE = 2'b10
    } if_id_ctl_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register with load / hold / bubble control; 1-cycle latency.
// Backpressure: a HOLD control freezes the contents; BUBBLE inserts a dead NOP.
module if_id_register #(
    parameter logic [31:0] NOP_WORD = instruction_fetch_stage_pkg::NOP_WORD
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  instruction_fetch_stage_pkg::if_id_ctl_t i_ctl,
    input  instruction_fetch_stage_pkg::if_id_t     i_dat,
    output instruction_fetch_stage_pkg::if_id_t     o_dat
);
    import instruction_fetch_stage_pkg::*;

    if_id_t r_dat;
    if_id_t w_bubble;

    always_comb begin
        w_bubble             = '0;
        w_bubble.instruction = NOP_WORD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dat <= w_bubble;
        end else begin
            case (i_ctl)
                IFID_LOAD:   r_dat <= i_dat;
                IFID_BUBBLE: r_dat <= w_bubble;
                default:     r_dat <= r_dat;
            endcase
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches one word per cycle into IF/ID; 1-cycle fetch latency.
// Backpressure: freeze holds PC, IF/ID and count; a taken branch still redirects during freeze.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = instruction_fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = instruction_fetch_stage_pkg::NOP_WORD,
    parameter int          COUNT_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               freeze,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_address,
    input  logic [31:0]        instruction,
    output logic [31:0]        instr_address,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_instruction,
    output logic               if_id_valid,
    output logic [COUNT_W-1:0] fetch_count
);
    import instruction_fetch_stage_pkg::*;

    logic [31:0]        r_pc;
    logic [COUNT_W-1:0] r_fetch_count;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_next_pc;
    logic               w_count_inc;
    if_id_ctl_t         w_ctl;
    if_id_t             w_load_dat;
    if_id_t             w_if_id;

    assign w_pc_plus4 = r_pc + 32'(WORD_BYTES);

    // Branch outranks freeze: the redirecting branch is older than the stalled instruction.
    always_comb begin
        w_next_pc   = w_pc_plus4;
        w_ctl       = IFID_LOAD;
        w_count_inc = 1'b0;
        if (branch_taken) begin
            w_next_pc = align_word(branch_address);
            w_ctl     = IFID_BUBBLE;
        end else if (freeze) begin
            w_next_pc = r_pc;
            w_ctl     = IFID_HOLD;
        end else if (flush) begin
            w_ctl     = IFID_BUBBLE;
        end else begin
            w_count_inc = 1'b1;
        end
    end

    always_comb begin
        w_load_dat             = '0;
        w_load_dat.pc          = w_pc_plus4;
        w_load_dat.instruction = instruction;
        w_load_dat.valid       = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_count_inc) begin
                r_fetch_count <= r_fetch_count + COUNT_W'(1);
            end
        end
    end

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clock (clock),
        .reset (reset),
        .i_ctl (w_ctl),
        .i_dat (w_load_dat),
        .o_dat (w_if_id)
    );

    assign instr_address     = r_pc;
    assign if_id_pc          = w_if_id.pc;
    assign if_id_instruction = w_if_id.instruction;
    assign if_id_valid       = w_if_id.valid;
    assign fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table plus randomized run against a reference model.
module tb_instruction_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        freeze;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [31:0] instruction;
    logic [31:0] instr_address;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    logic        m_valid;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0014;
        return 32'hE000_0000 ^ (a * 32'd2654435761) ^ 32'h0000_0AA5;
    endfunction

    assign instruction = mem_word(instr_address);

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000),
        .COUNT_W  (32)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .freeze            (freeze),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_address    (branch_address),
        .instruction       (instruction),
        .instr_address     (instr_address),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one edge of the stage from the rules, using the current inputs.
    task automatic model_step();
        if (reset) begin
            m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
        end else if (branch_taken) begin
            m_pc = branch_address & ~32'h3;
            m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (freeze) begin
            // everything holds
        end else if (flush) begin
            m_pc = m_pc + 32'd4;
            m_ifpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic apply(input logic rst, input logic frz, input logic fl,
                         input logic br, input logic [31:0] ba);
        reset = rst; freeze = frz; flush = fl; branch_taken = br; branch_address = ba;
        #1;
        model_step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst, frz, fl, br;
        logic [31:0] ba;
        logic [31:0] e_addr, e_ifpc, e_instr;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        reset = 1'b1; freeze = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;

        //            rst  frz  fl   br   ba            addr          ifpc          instr                      v    cnt
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,                     1'b0,32'd0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,                     1'b0,32'd0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h4,        32'hE3A0_0014,             1'b1,32'd1};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h8,        32'h8,        mem_word(32'h4),           1'b1,32'd2};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h8,        mem_word(32'h4),           1'b1,32'd2};
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h8,        mem_word(32'h4),           1'b1,32'd2};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'hC,        32'hC,        mem_word(32'h8),           1'b1,32'd3};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h10,       32'h10,       mem_word(32'hC),           1'b1,32'd4};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,        32'h14,       32'h0,        32'h0,                     1'b0,32'd4};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,32'h63,       32'h60,       32'h0,        32'h0,                     1'b0,32'd4};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h64,       32'h64,       mem_word(32'h60),          1'b1,32'd5};
        tbl[11] = '{1'b0,1'b1,1'b0,1'b1,32'h58,       32'h58,       32'h0,        32'h0,                     1'b0,32'd5};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h5C,       32'h5C,       mem_word(32'h58),          1'b1,32'd6};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,        32'h0,                     1'b0,32'd6};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        mem_word(32'hFFFF_FFFC),   1'b1,32'd7};
        tbl[15] = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        mem_word(32'hFFFF_FFFC),   1'b1,32'd7};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,                     1'b0,32'd0};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'h4,        32'h4,        32'hE3A0_0014,             1'b1,32'd1};

        #2;
        chk("reset_addr_pre", instr_address, 32'h0);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].rst, tbl[i].frz, tbl[i].fl, tbl[i].br, tbl[i].ba);
            chk($sformatf("v%0d_addr", i),  instr_address,      tbl[i].e_addr);
            chk($sformatf("v%0d_ifpc", i),  if_id_pc,           tbl[i].e_ifpc);
            chk($sformatf("v%0d_instr", i), if_id_instruction,  tbl[i].e_instr);
            chk($sformatf("v%0d_valid", i), 32'(if_id_valid),   32'(tbl[i].e_valid));
            chk($sformatf("v%0d_cnt", i),   fetch_count,        tbl[i].e_cnt);
        end

        // Self-loop branch: repeatedly redirect to the same target.
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
            chk("selfloop_addr", instr_address, 32'h100);
            chk("selfloop_valid", 32'(if_id_valid), 32'h0);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
            apply($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, ba);
            chk("rnd_addr",  instr_address,     m_pc);
            chk("rnd_ifpc",  if_id_pc,          m_ifpc);
            chk("rnd_instr", if_id_instruction, m_instr);
            chk("rnd_valid", 32'(if_id_valid),  32'(m_valid));
            chk("rnd_cnt",   fetch_count,       m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
